regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register bank's single write port (REG_WR_SEL/REG_INPUT_BUS) and the PC load port among three
//  writeback requesters: ALU result, memory load, and branch/link unit.
//  Round-robin arbitration, one registered output stage.
//  Dest index 15 (the PC) is steered to PC_IN_BUS/PC_REG_EN instead of the register write port.
//  Sits between the execute/memory units and the CPU register bank.
// PARAMETERS
//  NUM_REQ   3   number of requesters; fixed at 3 in this revision
//  DATA_W    32  width of writeback data
//  IDX_W     4   register index width; index 15 = PC
// PORTS
//  CLK             in   1       system clock, rising edge
//  RST             in   1       synchronous active-high reset
//  WB_STALL        in   1       1 = freeze output stage, accept nothing
//  REQ_VALID       in   3       per-requester write request; [0]=ALU [1]=LOAD [2]=LINK
//  REQ_READY       out  3       per-requester accept; one-hot or zero
//  REQ_IDX         in   3*4     per-requester destination index
//  REQ_DATA        in   3*32    per-requester data
//  REG_WR_SEL      out  4       to register bank write decoder; 4'hF = no GPR write
//  REG_INPUT_BUS   out  32      to register bank data input
//  PC_REG_EN       out  1       PC load enable
//  PC_IN_BUS       out  32      PC load value
//  OP0_REG_OUT_SEL in   4       read-port select, used only by the bypass option
//  OP1_REG_OUT_SEL in   4       read-port select, used only by the bypass option
//  OP0_FWD_VALID   out  1       bypass option only
//  OP1_FWD_VALID   out  1       bypass option only
//  OP_FWD_DATA     out  32      bypass option only
// BEHAVIOUR
//  Reset: RST sampled on the CLK edge.
//   - REG_WR_SEL=4'hF, REG_INPUT_BUS=0, PC_REG_EN=0, PC_IN_BUS=0, RR pointer=0 (ALU highest), REQ_READY=0.
//   - REQ_READY is forced 0 while RST=1.
//  Arbitration:
//   - REQ_READY[i] is combinational and goes high only when REQ_VALID[i]=1, !WB_STALL, !RST and i wins round-robin.
//   - Priority order starts at pointer p: p, p+1, p+2 mod 3.
//   - On a transfer (valid & ready), p <= winner+1 mod 3. With no transfer, p holds.
//  Handshake:
//   - Transfer = REQ_VALID[i] & REQ_READY[i].
//   - Requesters hold VALID/IDX/DATA stable until their transfer.
//   - VALID with no ready is legal and must not be lost.
//  Stage:
//   - Transfer in cycle N with IDX<15: REG_WR_SEL=IDX and REG_INPUT_BUS=DATA during cycle N+1.
//     The bank register updates at the end of N+1 and is readable in N+2.
//   - Transfer with IDX=15: PC_REG_EN=1 and PC_IN_BUS=DATA during N+1; REG_WR_SEL=4'hF.
//   - No transfer and !WB_STALL: REG_WR_SEL=4'hF and PC_REG_EN=0 next cycle. REG_INPUT_BUS and PC_IN_BUS hold.
//  WB_STALL=1:
//   - Stage outputs are forced idle (REG_WR_SEL=4'hF, PC_REG_EN=0) and nothing is accepted.
//   - Data outputs hold their value.
//   - The pointer holds.
//  Throughput: one write per cycle when not stalled; back-to-back writes to the same index are allowed, last wins.
//  States: IDLE (sel=F) / WRITE_GPR / WRITE_PC, determined by the stage register. No multi-cycle FSM beyond the pointer.
// CONFIGURATION
//  Macro WB_BYPASS_EN.
//  Defined: the bypass outputs are live.
//   - OPn_FWD_VALID=1 when the stage holds a GPR write (REG_WR_SEL!=4'hF) and REG_WR_SEL==OPn_REG_OUT_SEL.
//   - OP_FWD_DATA=REG_INPUT_BUS.
//   - Both outputs are combinational.
//  Undefined: OP0_FWD_VALID=OP1_FWD_VALID=0 and OP_FWD_DATA=0. The ports still exist.
// STRUCTURE
//  Package cpu_regs_pkg:
//   - IDX_W=4, PC_IDX=4'hF, NO_WR_SEL=4'hF
//   - typedef req_id_e {REQ_ALU=0, REQ_LOAD=1, REQ_LINK=2}
//  Sub-module rr_arbiter3:
//   - Inputs: CLK, RST, req[2:0], advance. Output: grant[2:0].
//   - Owns the pointer; combinational one-hot grant.
//  Top level: stage registers, PC steering, bypass compare.
// TESTING
//  1. Reset: RST=1 two cycles with all VALID=1 -> REQ_READY=0, REG_WR_SEL=F, PC_REG_EN=0, and the same in the cycle after release.
//  2. Single write: ALU VALID, IDX=3, DATA=32'hDEADBEEF in cycle N -> READY[0]=1 in N; SEL=3, BUS=DEADBEEF in N+1; SEL=F in N+2.
//  3. Contention: all three VALID continuously from reset -> grant order ALU, LOAD, LINK, ALU; READY is one-hot each cycle.
//  4. PC steer: LINK IDX=15, DATA=32'h100 -> PC_REG_EN=1, PC_IN_BUS=32'h100, REG_WR_SEL=F next cycle.
//  5. Stall: LOAD VALID with WB_STALL=1 for 3 cycles -> READY=0 and SEL=F throughout. Stall drop -> accepted, pointer unchanged.
//  6. WB_BYPASS_EN: stage SEL=5, OP0_SEL=5, OP1_SEL=6 -> OP0_FWD_VALID=1, OP1_FWD_VALID=0, FWD_DATA=stage data.
//     Without the macro both are 0.

Source files
------------

// File: rtl/cpu_regs_pkg.sv
// Shared constants and requester identifiers for the register-bank writeback path.
// Includes the round-robin helper used by the writeback arbiter.
package cpu_regs_pkg;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 4;

    localparam logic [IDX_W-1:0] PC_IDX    = 4'hF;
    localparam logic [IDX_W-1:0] NO_WR_SEL = 4'hF;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_LINK = 2'd2
    } req_id_e;

    function automatic req_id_e next_req(input req_id_e r);
        case (r)
            REQ_ALU:  return REQ_LOAD;
            REQ_LOAD: return REQ_LINK;
            default:  return REQ_ALU;
        endcase
    endfunction

    function automatic req_id_e req_rotate(input req_id_e base, input int unsigned steps);
        req_id_e r;
        r = base;
        for (int unsigned s = 0; s < steps; s++) begin
            r = next_req(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, pointer moves past the
// winner only when the grant is actually consumed (advance).
module rr_arbiter3
    import cpu_regs_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    req_id_e ptr_reg;
    req_id_e winner;
    req_id_e cand [NUM_REQ];
    logic    found;

    // cand[k] is the requester holding priority rank k for the current pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = req_rotate(ptr_reg, gi);
        end
    endgenerate

    always_comb begin
        grant  = '0;
        winner = ptr_reg;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand[k]]) begin
                grant[cand[k]] = 1'b1;
                winner         = cand[k];
                found          = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_reg <= REQ_ALU;
        end else if (advance) begin
            ptr_reg <= next_req(winner);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register-bank write port and PC load port among ALU, LOAD
// and LINK requesters. Optional operand bypass outputs are enabled with macro WB_BYPASS_EN.
module regfile_wb_arbiter
    import cpu_regs_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WB_STALL,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    output logic [NUM_REQ-1:0]         REQ_READY,
    input  logic [NUM_REQ*IDX_W-1:0]   REQ_IDX,
    input  logic [NUM_REQ*DATA_W-1:0]  REQ_DATA,
    output logic [IDX_W-1:0]           REG_WR_SEL,
    output logic [DATA_W-1:0]          REG_INPUT_BUS,
    output logic                       PC_REG_EN,
    output logic [DATA_W-1:0]          PC_IN_BUS,
    input  logic [IDX_W-1:0]           OP0_REG_OUT_SEL,
    input  logic [IDX_W-1:0]           OP1_REG_OUT_SEL,
    output logic                       OP0_FWD_VALID,
    output logic                       OP1_FWD_VALID,
    output logic [DATA_W-1:0]          OP_FWD_DATA
);

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               transfer;
    logic [IDX_W-1:0]   idx_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;

    logic [IDX_W-1:0]   wr_sel_reg;
    logic [DATA_W-1:0]  wr_data_reg;
    logic               pc_en_reg;
    logic [DATA_W-1:0]  pc_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign idx_arr[gi]  = REQ_IDX[gi*IDX_W +: IDX_W];
            assign data_arr[gi] = REQ_DATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter3 u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (REQ_VALID),
        .advance (transfer),
        .grant   (grant)
    );

    // A stalled or resetting stage must not consume a grant, so the pointer only moves on a real transfer
    assign accept    = ~WB_STALL & ~RST;
    assign REQ_READY = grant & {NUM_REQ{accept}};
    assign transfer  = |REQ_READY;

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (REQ_READY[i]) begin
                win_idx  = idx_arr[i];
                win_data = data_arr[i];
            end
        end
    end

    // Idle stage keeps the last data values on both buses; only the enables drop
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_sel_reg  <= NO_WR_SEL;
            wr_data_reg <= '0;
            pc_en_reg   <= 1'b0;
            pc_data_reg <= '0;
        end else if (!transfer) begin
            wr_sel_reg  <= NO_WR_SEL;
            pc_en_reg   <= 1'b0;
        end else if (win_idx == PC_IDX) begin
            wr_sel_reg  <= NO_WR_SEL;
            pc_en_reg   <= 1'b1;
            pc_data_reg <= win_data;
        end else begin
            wr_sel_reg  <= win_idx;
            wr_data_reg <= win_data;
            pc_en_reg   <= 1'b0;
        end
    end

    assign REG_WR_SEL    = wr_sel_reg;
    assign REG_INPUT_BUS = wr_data_reg;
    assign PC_REG_EN     = pc_en_reg;
    assign PC_IN_BUS     = pc_data_reg;

`ifdef WB_BYPASS_EN
    assign OP0_FWD_VALID = (wr_sel_reg != NO_WR_SEL) && (wr_sel_reg == OP0_REG_OUT_SEL);
    assign OP1_FWD_VALID = (wr_sel_reg != NO_WR_SEL) && (wr_sel_reg == OP1_REG_OUT_SEL);
    assign OP_FWD_DATA   = wr_data_reg;
`else
    logic unused_op_sel;
    assign unused_op_sel = ^{OP0_REG_OUT_SEL, OP1_REG_OUT_SEL};
    assign OP0_FWD_VALID = 1'b0;
    assign OP1_FWD_VALID = 1'b0;
    assign OP_FWD_DATA   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic,
// all compared against a cycle-level reference model of the writeback rules.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_STALL;
    logic [2:0]  REQ_VALID;
    logic [2:0]  REQ_READY;
    logic [11:0] REQ_IDX;
    logic [95:0] REQ_DATA;
    logic [3:0]  REG_WR_SEL;
    logic [31:0] REG_INPUT_BUS;
    logic        PC_REG_EN;
    logic [31:0] PC_IN_BUS;
    logic [3:0]  OP0_REG_OUT_SEL;
    logic [3:0]  OP1_REG_OUT_SEL;
    logic        OP0_FWD_VALID;
    logic        OP1_FWD_VALID;
    logic [31:0] OP_FWD_DATA;

    logic [3:0]  idx  [3];
    logic [31:0] data [3];

    assign REQ_IDX  = {idx[2], idx[1], idx[0]};
    assign REQ_DATA = {data[2], data[1], data[0]};

    always #5 CLK = ~CLK;

    regfile_wb_arbiter dut (
        .CLK             (CLK),
        .RST             (RST),
        .WB_STALL        (WB_STALL),
        .REQ_VALID       (REQ_VALID),
        .REQ_READY       (REQ_READY),
        .REQ_IDX         (REQ_IDX),
        .REQ_DATA        (REQ_DATA),
        .REG_WR_SEL      (REG_WR_SEL),
        .REG_INPUT_BUS   (REG_INPUT_BUS),
        .PC_REG_EN       (PC_REG_EN),
        .PC_IN_BUS       (PC_IN_BUS),
        .OP0_REG_OUT_SEL (OP0_REG_OUT_SEL),
        .OP1_REG_OUT_SEL (OP1_REG_OUT_SEL),
        .OP0_FWD_VALID   (OP0_FWD_VALID),
        .OP1_FWD_VALID   (OP1_FWD_VALID),
        .OP_FWD_DATA     (OP_FWD_DATA)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: priority start, and what the output stage should show
    int          m_p;
    logic [3:0]  m_sel;
    logic [31:0] m_data;
    logic        m_pc_en;
    logic [31:0] m_pc_data;
    logic [2:0]  m_last_ready;
    logic [2:0]  obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs, advance the model, check the stage after the edge
    task automatic tick();
        logic [2:0] exp_ready;
        logic       found;
        logic       fwd0;
        logic       fwd1;
        int         w;
        #1;
        exp_ready = 3'b000;
        found     = 1'b0;
        w         = 0;
        if (!RST && !WB_STALL) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && REQ_VALID[(m_p + k) % 3]) begin
                    w            = (m_p + k) % 3;
                    exp_ready[w] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
        obs_ready = REQ_READY;
        check("ready", {29'd0, REQ_READY}, {29'd0, exp_ready});
`ifdef WB_BYPASS_EN
        fwd0 = (m_sel != 4'hF) && (m_sel == OP0_REG_OUT_SEL);
        fwd1 = (m_sel != 4'hF) && (m_sel == OP1_REG_OUT_SEL);
        check("fwd_data", OP_FWD_DATA, m_data);
`else
        fwd0 = 1'b0;
        fwd1 = 1'b0;
        check("fwd_data", OP_FWD_DATA, 32'd0);
`endif
        check("fwd0", {31'd0, OP0_FWD_VALID}, {31'd0, fwd0});
        check("fwd1", {31'd0, OP1_FWD_VALID}, {31'd0, fwd1});

        if (RST) begin
            m_p = 0; m_sel = 4'hF; m_data = 0; m_pc_en = 0; m_pc_data = 0;
        end else if (found) begin
            m_p = (w + 1) % 3;
            if (idx[w] == 4'hF) begin
                m_sel = 4'hF; m_pc_en = 1'b1; m_pc_data = data[w];
            end else begin
                m_sel = idx[w]; m_data = data[w]; m_pc_en = 1'b0;
            end
        end else begin
            m_sel = 4'hF; m_pc_en = 1'b0;
        end
        m_last_ready = exp_ready;

        @(posedge CLK);
        #1;
        check("wr_sel", {28'd0, REG_WR_SEL}, {28'd0, m_sel});
        check("wr_bus", REG_INPUT_BUS, m_data);
        check("pc_en", {31'd0, PC_REG_EN}, {31'd0, m_pc_en});
        check("pc_bus", PC_IN_BUS, m_pc_data);
    endtask

    initial begin
        RST = 1'b1; WB_STALL = 1'b0; REQ_VALID = 3'b111;
        OP0_REG_OUT_SEL = 4'd5; OP1_REG_OUT_SEL = 4'd6;
        idx[0] = 4'd1; idx[1] = 4'd2; idx[2] = 4'd4;
        data[0] = 32'hA0; data[1] = 32'hB1; data[2] = 32'hC2;
        m_p = 0; m_sel = 4'hF; m_data = 0; m_pc_en = 0; m_pc_data = 0; m_last_ready = 0;
        obs_ready = 0;
        @(posedge CLK); #1;

        // Reset held two cycles with every requester valid
        tick();
        check("rst_ready", {29'd0, obs_ready}, 32'd0);
        tick();
        check("rst_ready2", {29'd0, obs_ready}, 32'd0);
        check("rst_sel", {28'd0, REG_WR_SEL}, 32'hF);

        // Contention straight out of reset: ALU, LOAD, LINK, ALU
        RST = 1'b0;
        tick();
        check("rr_0", {29'd0, obs_ready}, 32'd1);
        tick();
        check("rr_1", {29'd0, obs_ready}, 32'd2);
        tick();
        check("rr_2", {29'd0, obs_ready}, 32'd4);
        tick();
        check("rr_3", {29'd0, obs_ready}, 32'd1);
        REQ_VALID = 3'b000;
        tick();

        // Single ALU write of DEADBEEF to r3, then idle
        REQ_VALID = 3'b001; idx[0] = 4'd3; data[0] = 32'hDEADBEEF;
        tick();
        check("single_ready", {29'd0, obs_ready}, 32'd1);
        check("single_sel", {28'd0, REG_WR_SEL}, 32'd3);
        check("single_bus", REG_INPUT_BUS, 32'hDEADBEEF);
        REQ_VALID = 3'b000;
        tick();
        check("single_idle", {28'd0, REG_WR_SEL}, 32'hF);

        // LINK targeting the PC
        REQ_VALID = 3'b100; idx[2] = 4'hF; data[2] = 32'h100;
        tick();
        check("pc_en_set", {31'd0, PC_REG_EN}, 32'd1);
        check("pc_val", PC_IN_BUS, 32'h100);
        check("pc_no_gpr", {28'd0, REG_WR_SEL}, 32'hF);
        REQ_VALID = 3'b000;
        tick();

        // LOAD held off by three stall cycles, then accepted
        WB_STALL = 1'b1; REQ_VALID = 3'b010; idx[1] = 4'd9; data[1] = 32'h1234_5678;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_ready", {29'd0, obs_ready}, 32'd0);
            check("stall_sel", {28'd0, REG_WR_SEL}, 32'hF);
        end
        WB_STALL = 1'b0;
        tick();
        check("unstall_ready", {29'd0, obs_ready}, 32'd2);
        check("unstall_sel", {28'd0, REG_WR_SEL}, 32'd9);

        // Bypass probe: stage holds r5, operand selects 5 and 6
        REQ_VALID = 3'b001; idx[0] = 4'd5; data[0] = 32'hCAFE_0005;
        tick();
        REQ_VALID = 3'b000;
        #1;
`ifdef WB_BYPASS_EN
        check("byp_op0", {31'd0, OP0_FWD_VALID}, 32'd1);
        check("byp_data", OP_FWD_DATA, 32'hCAFE_0005);
`else
        check("byp_op0", {31'd0, OP0_FWD_VALID}, 32'd0);
        check("byp_data", OP_FWD_DATA, 32'd0);
`endif
        check("byp_op1", {31'd0, OP1_FWD_VALID}, 32'd0);
        tick();

        // Randomized traffic; a requester keeps its request unchanged until it transfers
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!REQ_VALID[i] || m_last_ready[i]) begin
                    REQ_VALID[i] = ($urandom_range(0, 9) < 6);
                    idx[i]       = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                    data[i]      = $urandom;
                end
            end
            WB_STALL = ($urandom_range(0, 4) == 0);
            RST      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) begin
                OP0_REG_OUT_SEL = 4'($urandom_range(0, 15));
                OP1_REG_OUT_SEL = 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
